// File: rtl/ctrl_pipe_tracker.sv
// ctrl_pipe_tracker: carries the decoded control word through ID/EX, EX/MEM, MEM/WB and sequences halt.
// Define CTRL_PERF_CNT_EN to build the retired/bubble performance counters.
module ctrl_pipe_tracker #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic             id_ALUSrc,
  input  logic             id_MemtoReg,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_Branch,
  input  logic             id_halt,
  input  logic [2:0]       id_ALUOp,
  input  logic [1:0]       id_JalType,
  input  logic             stall,
  input  logic             flush,
  output logic             ex_ALUSrc,
  output logic             ex_Branch,
  output logic             ex_MemRead,
  output logic             ex_valid,
  output logic [2:0]       ex_ALUOp,
  output logic [1:0]       ex_JalType,
  output logic             mem_MemRead,
  output logic             mem_MemWrite,
  output logic             mem_RegWrite,
  output logic             mem_MemtoReg,
  output logic             mem_valid,
  output logic             wb_RegWrite,
  output logic             wb_MemtoReg,
  output logic             wb_valid,
  output logic             fetch_stop,
  output logic             cpu_halted,
  output logic [CNT_W-1:0] perf_retired,
  output logic [CNT_W-1:0] perf_bubbles
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALTED} state_t;

  typedef struct packed {
    logic       alu_src;
    logic [2:0] alu_op;
    logic [1:0] jal_type;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       halt;
    logic       valid;
  } ex_ctrl_t;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
    logic halt;
    logic valid;
  } mem_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
    logic halt;
    logic valid;
  } wb_ctrl_t;

  state_t    state_q, state_d;
  ex_ctrl_t  ex_q, ex_d;
  mem_ctrl_t mem_q, mem_d;
  wb_ctrl_t  wb_q, wb_d;
  logic      halted_q, halted_d;
  logic      accept;

  // NOTE: combinational blocks use blocking '=' with every output defaulted first, so no latch is inferred.
  always_comb begin
    accept = (state_q == ST_RUN) && id_valid && !flush && !stall;

    ex_d = '0;
    if (accept) begin
      ex_d.alu_src    = id_ALUSrc;
      ex_d.alu_op     = id_ALUOp;
      ex_d.jal_type   = id_JalType;
      ex_d.branch     = id_Branch;
      ex_d.mem_read   = id_MemRead;
      ex_d.mem_write  = id_MemWrite;
      ex_d.reg_write  = id_RegWrite;
      ex_d.mem_to_reg = id_MemtoReg;
      ex_d.halt       = id_halt;
      ex_d.valid      = 1'b1;
    end

    // Downstream stages never stall: a bubble only ever enters at EX.
    mem_d.mem_read   = ex_q.mem_read;
    mem_d.mem_write  = ex_q.mem_write;
    mem_d.reg_write  = ex_q.reg_write;
    mem_d.mem_to_reg = ex_q.mem_to_reg;
    mem_d.halt       = ex_q.halt;
    mem_d.valid      = ex_q.valid;

    wb_d.reg_write  = mem_q.reg_write;
    wb_d.mem_to_reg = mem_q.mem_to_reg;
    wb_d.halt       = mem_q.halt;
    wb_d.valid      = mem_q.valid;

    state_d = state_q;
    case (state_q)
      ST_RUN:   if (accept && id_halt) state_d = ST_DRAIN;
      ST_DRAIN: if (wb_q.halt)         state_d = ST_HALTED;
      default:  state_d = state_q;
    endcase
    halted_d = (state_d == ST_HALTED);
  end

  // NOTE: sequential state uses non-blocking '<=' and every pipeline flop is cleared by the async reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RUN;
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ex_q     <= ex_d;
      mem_q    <= mem_d;
      wb_q     <= wb_d;
      halted_q <= halted_d;
    end
  end

  assign fetch_stop   = (state_q != ST_RUN) || (accept && id_halt);
  assign cpu_halted   = halted_q;

  assign ex_ALUSrc    = ex_q.alu_src;
  assign ex_Branch    = ex_q.branch;
  assign ex_MemRead   = ex_q.mem_read;
  assign ex_valid     = ex_q.valid;
  assign ex_ALUOp     = ex_q.alu_op;
  assign ex_JalType   = ex_q.jal_type;
  assign mem_MemRead  = mem_q.mem_read;
  assign mem_MemWrite = mem_q.mem_write;
  assign mem_RegWrite = mem_q.reg_write;
  assign mem_MemtoReg = mem_q.mem_to_reg;
  assign mem_valid    = mem_q.valid;
  assign wb_RegWrite  = wb_q.reg_write;
  assign wb_MemtoReg  = wb_q.mem_to_reg;
  assign wb_valid     = wb_q.valid;

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] retired_q, retired_d;
  logic [CNT_W-1:0] bubbles_q, bubbles_d;

  always_comb begin
    retired_d = retired_q;
    bubbles_d = bubbles_q;
    if (state_q != ST_HALTED) begin
      if (wb_q.valid) retired_d = retired_q + CNT_W'(1);
      // flush and stall together still make a single bubble.
      if ((state_q == ST_RUN) && (stall || flush)) bubbles_d = bubbles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= '0;
      bubbles_q <= '0;
    end else begin
      retired_q <= retired_d;
      bubbles_q <= bubbles_d;
    end
  end

  assign perf_retired = retired_q;
  assign perf_bubbles = bubbles_q;
`else
  assign perf_retired = '0;
  assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_tracker.sv
// Directed bench for ctrl_pipe_tracker: pipeline latency, stall/flush bubbles, halt drain and reset.
// Counter expectations follow CTRL_PERF_CNT_EN (zero when the feature is not built).
module tb_ctrl_pipe_tracker;

`ifdef CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk, reset;
  logic        id_valid, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_halt;
  logic [2:0]  id_ALUOp;
  logic [1:0]  id_JalType;
  logic        stall, flush;
  logic        ex_ALUSrc, ex_Branch, ex_MemRead, ex_valid;
  logic [2:0]  ex_ALUOp;
  logic [1:0]  ex_JalType;
  logic        mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg, mem_valid;
  logic        wb_RegWrite, wb_MemtoReg, wb_valid;
  logic        fetch_stop, cpu_halted;
  logic [31:0] perf_retired, perf_bubbles;

  int total = 0;
  int bad   = 0;

  ctrl_pipe_tracker #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ALUSrc(id_ALUSrc), .id_MemtoReg(id_MemtoReg), .id_RegWrite(id_RegWrite),
    .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite), .id_Branch(id_Branch), .id_halt(id_halt),
    .id_ALUOp(id_ALUOp), .id_JalType(id_JalType), .stall(stall), .flush(flush),
    .ex_ALUSrc(ex_ALUSrc), .ex_Branch(ex_Branch), .ex_MemRead(ex_MemRead), .ex_valid(ex_valid),
    .ex_ALUOp(ex_ALUOp), .ex_JalType(ex_JalType),
    .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_RegWrite(mem_RegWrite),
    .mem_MemtoReg(mem_MemtoReg), .mem_valid(mem_valid),
    .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_valid(wb_valid),
    .fetch_stop(fetch_stop), .cpu_halted(cpu_halted),
    .perf_retired(perf_retired), .perf_bubbles(perf_bubbles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pexp(input int n);
    return PERF ? 32'(n) : 32'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [1:0] jal, input logic alusrc,
                       input logic m2r, input logic rw, input logic mr, input logic mw,
                       input logic br, input logic hlt);
    id_valid = v;   id_ALUOp = op;   id_JalType = jal; id_ALUSrc = alusrc;
    id_MemtoReg = m2r; id_RegWrite = rw; id_MemRead = mr; id_MemWrite = mw;
    id_Branch = br; id_halt = hlt;
  endtask

  task automatic idle();
    drive(1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ex_valid"},   {31'd0, ex_valid},   32'd0);
    check({tag, "_ex_ALUOp"},   {29'd0, ex_ALUOp},   32'd0);
    check({tag, "_mem_valid"},  {31'd0, mem_valid},  32'd0);
    check({tag, "_wb_valid"},   {31'd0, wb_valid},   32'd0);
    check({tag, "_fetch_stop"}, {31'd0, fetch_stop}, 32'd0);
    check({tag, "_cpu_halted"}, {31'd0, cpu_halted}, 32'd0);
    check({tag, "_retired"},    perf_retired,        32'd0);
    check({tag, "_bubbles"},    perf_bubbles,        32'd0);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    idle();
    #12;
    check_zero("reset");
    @(negedge clk); reset = 1'b1;
    tick();

    // Straight-line: R-type then LW.
    drive(1'b1, 3'b010, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("sl_ex_valid", {31'd0, ex_valid}, 32'd1);
    check("sl_ex_ALUOp", {29'd0, ex_ALUOp}, 32'd2);
    drive(1'b1, 3'b000, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check("sl_ex_MemRead", {31'd0, ex_MemRead}, 32'd1);
    check("sl_ex_ALUSrc",  {31'd0, ex_ALUSrc},  32'd1);
    check("sl_mem_RegWrite", {31'd0, mem_RegWrite}, 32'd1);
    idle();
    tick();
    check("sl_wb_RegWrite_r", {31'd0, wb_RegWrite}, 32'd1);
    check("sl_wb_MemtoReg_r", {31'd0, wb_MemtoReg}, 32'd0);
    check("sl_mem_MemtoReg",  {31'd0, mem_MemtoReg}, 32'd1);
    tick();
    check("sl_wb_MemtoReg_lw", {31'd0, wb_MemtoReg}, 32'd1);
    check("sl_wb_valid_lw",    {31'd0, wb_valid},    32'd1);
    check("sl_bubbles",        perf_bubbles,         32'd0);
    tick();
    check("sl_wb_drained", {31'd0, wb_valid}, 32'd0);
    check("sl_retired",    perf_retired,      pexp(2));

    // Load-use stall with SW in ID.
    drive(1'b1, 3'b000, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    stall = 1'b1;
    tick();
    check("st_ex_valid_bubble", {31'd0, ex_valid}, 32'd0);
    check("st_bubbles",         perf_bubbles,      pexp(1));
    stall = 1'b0;
    tick();
    check("st_ex_valid_cap", {31'd0, ex_valid},  32'd1);
    check("st_ex_ALUSrc",    {31'd0, ex_ALUSrc}, 32'd1);
    idle();
    tick();
    check("st_mem_MemWrite", {31'd0, mem_MemWrite}, 32'd1);
    tick();
    check("st_wb_valid", {31'd0, wb_valid}, 32'd1);

    // Branch flush, then flush+stall together (one bubble each).
    drive(1'b1, 3'b010, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    check("fl_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("fl_bubbles",  perf_bubbles,      pexp(2));
    stall = 1'b1;
    tick();
    check("fs_ex_valid", {31'd0, ex_valid}, 32'd0);
    check("fs_bubbles",  perf_bubbles,      pexp(3));
    flush = 1'b0; stall = 1'b0;
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_wb_RegWrite", {31'd0, wb_RegWrite}, 32'd0);
      check("fl_mem_valid",   {31'd0, mem_valid},   32'd0);
    end
    check("fl_retired", perf_retired, pexp(3));

    // Halt killed by flush: no state change.
    drive(1'b1, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    flush = 1'b1;
    #1;
    check("hk_fetch_stop_same", {31'd0, fetch_stop}, 32'd0);
    tick();
    flush = 1'b0;
    drive(1'b1, 3'b001, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #1;
    check("hk_fetch_stop_next", {31'd0, fetch_stop}, 32'd0);
    check("hk_ex_valid",        {31'd0, ex_valid},   32'd0);
    check("hk_cpu_halted",      {31'd0, cpu_halted}, 32'd0);
    check("hk_bubbles",         perf_bubbles,        pexp(4));
    tick();
    check("hk_run_ex_valid",   {31'd0, ex_valid},   32'd1);
    check("hk_run_ex_JalType", {30'd0, ex_JalType}, 32'd2);
    check("hk_run_ex_Branch",  {31'd0, ex_Branch},  32'd1);

    // Halt under stall is retried next cycle, then drains to HALTED.
    drive(1'b1, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    stall = 1'b1;
    #1;
    check("hs_fetch_stop_stalled", {31'd0, fetch_stop}, 32'd0);
    tick();
    check("hs_ex_valid_bubble", {31'd0, ex_valid}, 32'd0);
    stall = 1'b0;
    #1;
    check("hs_fetch_stop_accept", {31'd0, fetch_stop}, 32'd1);
    tick();
    check("hs_ex_valid_halt", {31'd0, ex_valid}, 32'd1);
    drive(1'b1, 3'b010, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("hs_fetch_stop_drain", {31'd0, fetch_stop}, 32'd1);
    tick();
    tick();
    check("hs_not_yet_halted", {31'd0, cpu_halted}, 32'd0);
    tick();
    check("hs_cpu_halted", {31'd0, cpu_halted}, 32'd1);
    check("hs_retired",    perf_retired,        pexp(5));
    check("hs_bubbles",    perf_bubbles,        pexp(5));
    stall = 1'b1;
    tick();
    stall = 1'b0;
    check("hs_absorb_halted", {31'd0, cpu_halted}, 32'd1);
    check("hs_absorb_ex",     {31'd0, ex_valid},   32'd0);
    check("hs_frozen_bubbles", perf_bubbles,       pexp(5));
    check("hs_frozen_retired", perf_retired,       pexp(5));

    // Async reset out of HALTED.
    #1 reset = 1'b0;
    #1;
    check_zero("rst_halted");
    idle();
    @(negedge clk); reset = 1'b1;
    tick();

    // Halt drain: LW, ADD, halt on cycles 0, 1, 2.
    drive(1'b1, 3'b000, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("hd_c0_fetch_stop", {31'd0, fetch_stop}, 32'd0);
    tick();
    drive(1'b1, 3'b010, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("hd_c1_ex_MemRead", {31'd0, ex_MemRead}, 32'd1);
    tick();
    drive(1'b1, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    check("hd_c2_fetch_stop", {31'd0, fetch_stop}, 32'd1);
    tick();
    drive(1'b1, 3'b010, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("hd_c3_fetch_stop",  {31'd0, fetch_stop},  32'd1);
    check("hd_c3_wb_MemtoReg", {31'd0, wb_MemtoReg}, 32'd1);
    check("hd_c3_ex_valid",    {31'd0, ex_valid},    32'd1);
    tick();
    check("hd_c4_wb_RegWrite", {31'd0, wb_RegWrite}, 32'd1);
    check("hd_c4_wb_MemtoReg", {31'd0, wb_MemtoReg}, 32'd0);
    check("hd_c4_ex_bubble",   {31'd0, ex_valid},    32'd0);
    tick();
    check("hd_c5_wb_valid",   {31'd0, wb_valid},   32'd1);
    check("hd_c5_cpu_halted", {31'd0, cpu_halted}, 32'd0);
    tick();
    check("hd_c6_cpu_halted", {31'd0, cpu_halted}, 32'd1);
    check("hd_c6_wb_valid",   {31'd0, wb_valid},   32'd0);
    check("hd_c6_retired",    perf_retired,        pexp(3));
    check("hd_c6_bubbles",    perf_bubbles,        32'd0);

    // Reset asserted mid-drain.
    #1 reset = 1'b0;
    #1 idle();
    @(negedge clk); reset = 1'b1;
    tick();
    drive(1'b1, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 3'b011, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rd_ex_valid_halt", {31'd0, ex_valid},   32'd1);
    check("rd_fetch_stop",    {31'd0, fetch_stop}, 32'd1);
    reset = 1'b0;
    idle();
    #1;
    check_zero("rd_async");
    @(negedge clk); reset = 1'b1;
    drive(1'b1, 3'b011, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("rd_run_fetch_stop", {31'd0, fetch_stop}, 32'd0);
    tick();
    check("rd_run_ex_valid", {31'd0, ex_valid}, 32'd1);
    check("rd_run_ex_ALUOp", {29'd0, ex_ALUOp}, 32'd3);
    idle();
    for (int i = 0; i < 5; i++) tick();
    check("rd_never_halted", {31'd0, cpu_halted}, 32'd0);
    check("rd_retired",      perf_retired,        pexp(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_tracker.md
Name: ctrl_pipe_tracker

Overview:
- Consumer end of the decode control bundle: receives the per-instruction control word produced in ID.
- Carries the control word through ID/EX, EX/MEM and MEM/WB pipeline registers, applying stall bubbles and branch flushes.
- Sequences processor halt: stops fetch once a halt enters EX, then drains older instructions and reports halted once the halt retires.

Parameters:
CNT_W, 32, width of the optional performance counters

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_halt  in  1 each  decoded control bits from ID
id_ALUOp  in  3  ALU operation class
id_JalType  in  2  {jal, jalr}
stall  in  1  load-use hazard: hold IF/ID, insert bubble into EX
flush  in  1  branch/jump taken in EX: kill the instruction in ID
ex_ALUSrc, ex_Branch, ex_MemRead, ex_valid  out  1 each  EX-stage control
ex_ALUOp  out  3; ex_JalType  out  2
mem_MemRead, mem_MemWrite, mem_RegWrite, mem_MemtoReg, mem_valid  out  1 each  MEM-stage control
wb_RegWrite, wb_MemtoReg, wb_valid  out  1 each  WB-stage control
fetch_stop  out  1  PC/IF/ID must not advance
cpu_halted  out  1  sticky, halt retired
perf_retired  out  CNT_W  valid instructions leaving WB (optional feature)
perf_bubbles  out  CNT_W  bubbles inserted into EX (optional feature)

Behaviour:
- Reset (reset=0, asynchronous):
  - All stage registers are cleared to 0, including the valid bits and the internal ex_/mem_/wb_halt bits.
  - State is RUN.
  - fetch_stop=0, cpu_halted=0, counters=0.
- Bubble definition: every control bit, halt bit and valid bit is 0.
- EX capture each edge, in priority order:
  - reset;
  - else bubble if flush, stall, state!=RUN, or id_valid=0;
  - else capture the id_* bundle with valid=1.
- MEM and WB always advance, one cycle per stage: EX->MEM->WB. Stall never freezes EX/MEM or MEM/WB.
- Latency: an accepted ID bundle appears on ex_* in the next cycle, mem_* one cycle later, wb_* one cycle after that.
- State machine:
  - RUN->DRAIN on the edge where a halt is captured into EX (id_halt=1, accepted).
  - DRAIN->HALTED on the edge where wb_halt=1 leaves WB, i.e. three cycles after entering DRAIN.
  - HALTED is absorbing; only reset leaves it.
- fetch_stop = (state!=RUN) | (accepted id_halt this cycle). Combinational; it stops the PC in the same cycle the halt is accepted.
- cpu_halted = (state==HALTED), registered.
- Instructions already in MEM/WB when the halt enters EX complete normally.
- Halt in ID with flush=1: the halt is killed and no state change occurs.
- Halt in ID with stall=1: the halt is not accepted and is retried next cycle.
- flush and stall in the same cycle produce a single bubble, counted once.
- Reset asserted mid-drain returns the block to RUN with empty stages.
- No combinational path from the id_* inputs to ex_/mem_/wb_ outputs.

Optional Feature:
Macro CTRL_PERF_CNT_EN.
- Defined:
  - perf_retired increments on each edge where wb_valid=1.
  - perf_bubbles increments on each edge where EX captures a bubble caused by stall or flush while state==RUN.
  - Both counters wrap modulo 2^CNT_W, clear on reset and freeze in HALTED.
- Undefined:
  - The counter logic is absent; both ports are tied to 0.
  - The ports are always present so instantiation is identical either way.

Test Plan:
- Straight-line: R-type (RegWrite=1, ALUOp=010) at cycle 0, then LW (MemRead=1, MemtoReg=1, ALUSrc=1) at cycle 1 -> ex_ALUOp=010 at cycle 1, wb_MemtoReg=1 at cycle 4, no bubbles.
- Load-use stall: stall=1 for one cycle with SW (MemWrite=1) in ID -> ex_valid=0 that cycle; SW is captured next cycle; mem_MemWrite=1 two cycles after capture; perf_bubbles=1.
- Branch flush: flush=1 while an instruction with RegWrite=1 is in ID -> ex_valid=0 next cycle; wb_RegWrite never pulses for it.
- Halt drain: LW, ADD, halt issued on consecutive cycles; halt accepted at cycle 2 ->
  - fetch_stop=1 from cycle 2;
  - LW reaches WB at cycle 3, ADD at cycle 4;
  - cpu_halted=1 at cycle 6;
  - perf_retired=3.
- Halt killed: id_halt=1 with flush=1 -> state stays RUN, fetch_stop=0 next cycle, cpu_halted stays 0.
- Reset mid-drain: reset=0 for one cycle during DRAIN -> all outputs 0 immediately (asynchronous); RUN resumes after release.
